// File: rtl/config_stream_loader.sv
// Column config writer: assembles a valid/ready word stream into a shadow register and commits it atomically.
// Define CONFIG_LOADER_CRC_EN to check a CRC-8 trailer beat before committing.
module config_stream_loader #(
  parameter int CONFIG_WIDTH = 582,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    load_start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    busy,
  output logic                    config_done,
  output logic                    config_error,
  output logic [CONFIG_WIDTH-1:0] config_out
);

  localparam int NB   = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int SW   = NB * WORD_WIDTH;
  localparam int CNTW = $clog2(NB + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRC,
    S_COMMIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                    r_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;
  logic [CNTW-1:0]         r_cnt;
  logic [SW-1:0]           r_shadow;
  logic [CONFIG_WIDTH-1:0] r_cfg;

  logic w_accept;
  logic w_last;
  logic w_enter;
  logic w_ready_d;
  logic w_busy_d;
  logic w_done_d;
  logic w_error_d;

  assign w_accept = data_valid & r_ready;
  assign w_last   = w_accept && (r_state == S_LOAD)
                    && (r_cnt == LAST);
  assign w_enter  = (r_state != S_LOAD) && (w_next == S_LOAD);

`ifdef CONFIG_LOADER_CRC_EN
  logic [7:0] r_crc;
  logic [7:0] w_crc_nxt;
  logic       w_crc_ok;

  // CRC-8, poly 0x07, MSB of each beat first
  function automatic logic [7:0] crc8_step(
    input logic [7:0]            c,
    input logic [WORD_WIDTH-1:0] d
  );
    logic [7:0] x;
    x = c;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (x[7] ^ d[i])
        x = {x[6:0], 1'b0} ^ 8'h07;
      else
        x = {x[6:0], 1'b0};
    end
    return x;
  endfunction

  assign w_crc_nxt = crc8_step(r_crc, data_in);
  assign w_crc_ok  = (data_in[7:0] == r_crc);
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_DONE,
      S_ERROR: begin
        if (load_start)
          w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_last)
`ifdef CONFIG_LOADER_CRC_EN
          w_next = S_CRC;
`else
          w_next = S_COMMIT;
`endif
      end
      S_CRC: begin
`ifdef CONFIG_LOADER_CRC_EN
        if (w_accept)
          w_next = w_crc_ok ? S_COMMIT : S_ERROR;
`else
        w_next = S_IDLE;
`endif
      end
      S_COMMIT: w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state
  always_comb begin
    w_ready_d = (w_next == S_LOAD) || (w_next == S_CRC);
    w_busy_d  = (w_next == S_LOAD) || (w_next == S_CRC)
                || (w_next == S_COMMIT);
    w_done_d  = (w_next == S_DONE);
`ifdef CONFIG_LOADER_CRC_EN
    w_error_d = (w_next == S_ERROR);
`else
    w_error_d = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_ready <= w_ready_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_error <= w_error_d;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else if (w_enter) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else if (w_accept && (r_state == S_LOAD)) begin
      r_cnt    <= r_cnt + 1'b1;
      r_shadow <= {data_in, r_shadow[SW-1:WORD_WIDTH]};
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)
      r_crc <= 8'h00;
    else if (w_enter)
      r_crc <= 8'h00;
    else if (w_accept && (r_state == S_LOAD))
      r_crc <= w_crc_nxt;
  end
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)
      r_cfg <= '0;
    else if (r_state == S_COMMIT)
      r_cfg <= r_shadow[CONFIG_WIDTH-1:0];
  end

  // Pad bits of the final beat never reach the column
  generate
    if (SW > CONFIG_WIDTH) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^r_shadow[SW-1:CONFIG_WIDTH];
    end
  endgenerate

  assign data_ready   = r_ready;
  assign busy         = r_busy;
  assign config_done  = r_done;
  assign config_error = r_error;
  assign config_out   = r_cfg;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: table of full loads plus
// reset, atomicity, ignored-start and CRC sequences.
module tb_config_stream_loader;

  localparam int CW = 582;
  localparam int W  = 8;
  localparam int NB = 73;

  logic          clock = 1'b0;
  logic          nreset = 1'b1;
  logic          load_start = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          busy;
  logic          config_done;
  logic          config_error;
  logic [CW-1:0] config_out;

  config_stream_loader #(
    .CONFIG_WIDTH(CW),
    .WORD_WIDTH(W)
  ) dut (
    .clock(clock),
    .nreset(nreset),
    .load_start(load_start),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .busy(busy),
    .config_done(config_done),
    .config_error(config_error),
    .config_out(config_out)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    int         gap;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    logic [5:0] exp_top;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm,
                     input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] beat(input logic [7:0] b,
                                      input logic [7:0] s,
                                      input int k);
    int v;
    v = int'(b) + int'(s) * k;
    return 8'(v);
  endfunction

  function automatic logic [CW-1:0] model(input logic [7:0] b,
                                          input logic [7:0] s);
    logic [NB*W-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++)
      v[k*W +: W] = beat(b, s, k);
    return v[CW-1:0];
  endfunction

  function automatic logic [7:0] crc_model(input logic [7:0] b,
                                           input logic [7:0] s);
    logic [7:0] c;
    logic [7:0] d;
    c = 8'h00;
    for (int k = 0; k < NB; k++) begin
      d = beat(b, s, k);
      for (int i = 7; i >= 0; i--) begin
        if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
        else             c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic start();
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Returns at the falling edge after the last accepted beat
  task automatic feed(input logic [7:0] b, input logic [7:0] s,
                      input int gap, input int k0, input int n,
                      input int pulse_at);
    int k;
    int cyc;
    int guard;
    k = k0;
    cyc = 0;
    guard = 0;
    while (k < k0 + n && guard < 2000) begin
      data_in    = beat(b, s, k);
      data_valid = !(gap > 0 && (cyc % gap) == gap - 1);
      load_start = (k == pulse_at) && data_valid;
      if (data_valid && data_ready) k++;
      cyc++;
      guard++;
      @(negedge clock);
    end
    data_valid = 1'b0;
    load_start = 1'b0;
    if (guard >= 2000) begin
      total++;
      bad++;
      $display("FAIL feed_timeout got=%0d want=%0d", k, k0 + n);
    end
  endtask

  task automatic trailer(input logic [7:0] c);
    int guard;
    guard = 0;
    while (!data_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    data_in    = c;
    data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL trailer_timeout got=0 want=1");
    end
  endtask

  task automatic full_load(input logic [7:0] b, input logic [7:0] s,
                           input int gap);
    start();
    feed(b, s, gap, 0, NB, -1);
`ifdef CONFIG_LOADER_CRC_EN
    trailer(crc_model(b, s));
`endif
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h01, 0, 8'h00, 8'h01, 6'h08};
    vecs[1] = '{8'h00, 8'h01, 3, 8'h00, 8'h01, 6'h08};
    vecs[2] = '{8'hFF, 8'h00, 0, 8'hFF, 8'hFF, 6'h3F};
    vecs[3] = '{8'h10, 8'h03, 2, 8'h10, 8'h13, 6'h28};
    vecs[4] = '{8'hA5, 8'h00, 0, 8'hA5, 8'hA5, 6'h25};

    #1 nreset = 1'b0;
    #1;
    chk("rst_out",   config_out, '0);
    chk("rst_ready", CW'(data_ready), '0);
    chk("rst_busy",  CW'(busy), '0);
    chk("rst_done",  CW'(config_done), '0);
    chk("rst_err",   CW'(config_error), '0);
    @(negedge clock);
    nreset = 1'b1;

    // Valid ignored while idle
    data_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    data_valid = 1'b0;
    chk("idle_ready", CW'(data_ready), '0);

    for (int i = 0; i < 5; i++) begin
      full_load(vecs[i].base, vecs[i].step, vecs[i].gap);
      chk($sformatf("v%0d_done_lat", i), CW'(config_done), '0);
      chk($sformatf("v%0d_busy_lat", i), CW'(busy), CW'(1));
      @(negedge clock);
      chk($sformatf("v%0d_done", i), CW'(config_done), CW'(1));
      chk($sformatf("v%0d_busy", i), CW'(busy), '0);
      chk($sformatf("v%0d_ready", i), CW'(data_ready), '0);
      chk($sformatf("v%0d_b0", i), CW'(config_out[7:0]),
          CW'(vecs[i].exp_b0));
      chk($sformatf("v%0d_b1", i), CW'(config_out[15:8]),
          CW'(vecs[i].exp_b1));
      chk($sformatf("v%0d_top", i), CW'(config_out[581:576]),
          CW'(vecs[i].exp_top));
      chk($sformatf("v%0d_full", i), config_out,
          model(vecs[i].base, vecs[i].step));
    end

    // Atomicity: partial reload must not disturb config_out
    full_load(8'hFF, 8'h00, 0);
    @(negedge clock);
    start();
    chk("atom_done_clr", CW'(config_done), '0);
    feed(8'h00, 8'h00, 0, 0, 40, -1);
    @(negedge clock);
    @(negedge clock);
    chk("atom_hold", config_out, {CW{1'b1}});
    chk("atom_done", CW'(config_done), '0);
    chk("atom_busy", CW'(busy), CW'(1));
    feed(8'h00, 8'h00, 0, 40, NB - 40, -1);
`ifdef CONFIG_LOADER_CRC_EN
    trailer(8'h00);
`endif
    chk("atom_hold2", config_out, {CW{1'b1}});
    @(negedge clock);
    chk("atom_zero", config_out, '0);
    chk("atom_done2", CW'(config_done), CW'(1));

    // load_start during LOAD is ignored
    start();
    feed(8'h00, 8'h01, 0, 0, NB, 20);
`ifdef CONFIG_LOADER_CRC_EN
    trailer(crc_model(8'h00, 8'h01));
`endif
    @(negedge clock);
    chk("ign_done", CW'(config_done), CW'(1));
    chk("ign_out", config_out, model(8'h00, 8'h01));

    // Asynchronous reset mid-load
    start();
    feed(8'h33, 8'h01, 0, 0, 10, -1);
    #2 nreset = 1'b0;
    #1;
    chk("arst_out",   config_out, '0);
    chk("arst_ready", CW'(data_ready), '0);
    chk("arst_done",  CW'(config_done), '0);
    chk("arst_busy",  CW'(busy), '0);
    @(negedge clock);
    nreset = 1'b1;

`ifdef CONFIG_LOADER_CRC_EN
    full_load(8'hA5, 8'h00, 0);
    @(negedge clock);
    chk("crc_ok_done", CW'(config_done), CW'(1));
    chk("crc_ok_err",  CW'(config_error), '0);
    start();
    feed(8'hA5, 8'h00, 0, 0, NB, -1);
    trailer(crc_model(8'hA5, 8'h00) ^ 8'h01);
    chk("crc_bad_err",   CW'(config_error), CW'(1));
    chk("crc_bad_done",  CW'(config_done), '0);
    chk("crc_bad_ready", CW'(data_ready), '0);
    chk("crc_bad_out",   config_out, model(8'hA5, 8'h00));
    start();
    chk("crc_err_clr",   CW'(config_error), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
